// File: rtl/volatility_buf_ctrl.sv
// rtl/volatility_buf_ctrl.sv - per-stock circular-buffer address controller with oldest->newest read sweep
// Optional VOL_BUF_CLEAR_EN adds a per-stock clear port (i_clear / i_clear_stock_id).
module volatility_buf_ctrl #(
    parameter int NUM_STOCKS  = 4,
    parameter int BUFFER_SIZE = 20,
    parameter int DATA_WIDTH  = 32,
    localparam int SID_W  = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
    localparam int ADDR_W = $clog2(NUM_STOCKS * BUFFER_SIZE),
    localparam int CNT_W  = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_window_len,
`ifdef VOL_BUF_CLEAR_EN
    input  logic                  i_clear,
    input  logic [SID_W-1:0]      i_clear_stock_id,
`endif
    input  logic                  i_wr_valid,
    input  logic [SID_W-1:0]      i_wr_stock_id,
    output logic                  o_wr_ready,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic                  o_wr_addr_vld,
    output logic [CNT_W-1:0]      o_fill,
    output logic                  o_window_full,
    input  logic                  i_rd_req,
    input  logic [SID_W-1:0]      i_rd_stock_id,
    input  logic                  i_rd_ready,
    output logic [ADDR_W-1:0]     o_rd_addr,
    output logic                  o_rd_addr_vld,
    output logic                  o_rd_last,
    output logic                  o_rd_done,
    output logic                  o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP, S_DONE} state_t;

    function automatic logic [2**SID_W-1:0] mk_sid_ok();
        logic [2**SID_W-1:0] ok;
        for (int i = 0; i < 2**SID_W; i++) ok[i] = (i < NUM_STOCKS);
        return ok;
    endfunction

    localparam logic [2**SID_W-1:0] SID_OK = mk_sid_ok();

    function automatic logic [ADDR_W-1:0] base_of(input logic [SID_W-1:0] sid);
        return ADDR_W'(int'(sid) * BUFFER_SIZE);
    endfunction

    state_t           state;
    logic [CNT_W-1:0] wr_ptr [NUM_STOCKS];
    logic [CNT_W-1:0] fill   [NUM_STOCKS];
    logic [CNT_W-1:0] win_len;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] rd_cnt;
    logic [SID_W-1:0] rd_sid;

    logic             clr_en;
    logic [SID_W-1:0] clr_sid;
`ifdef VOL_BUF_CLEAR_EN
    assign clr_en  = i_clear && SID_OK[i_clear_stock_id];
    assign clr_sid = i_clear_stock_id;
`else
    assign clr_en  = 1'b0;
    assign clr_sid = '0;
`endif

    logic             wr_ok;
    logic             wr_acc;
    logic             sweep_clr;
    logic [CNT_W-1:0] wr_fill;
    logic [CNT_W-1:0] ld_fill;
    logic [CNT_W-1:0] ld_ptr;
    logic [CNT_W-1:0] rd_nxt;

    assign wr_ok      = SID_OK[i_wr_stock_id];
    assign o_wr_ready = !((state != S_IDLE) && (i_wr_stock_id == rd_sid))
                        && !(clr_en && (clr_sid == i_wr_stock_id));
    assign wr_acc     = i_wr_valid && o_wr_ready && wr_ok;
    assign sweep_clr  = clr_en && (clr_sid == rd_sid) && (state == S_LOAD || state == S_SWEEP);

    always_comb begin
        wr_fill = '0;
        if (wr_ok) wr_fill = fill[i_wr_stock_id];
        ld_fill = fill[rd_sid];
        // Oldest entry sits fill slots behind the write pointer, modulo the window.
        ld_ptr  = wr_ptr[rd_sid] - ld_fill;
        if (wr_ptr[rd_sid] < ld_fill) ld_ptr = ld_ptr + win_len;
        rd_nxt  = (rd_ptr == win_len - CNT_W'(1)) ? '0 : rd_ptr + CNT_W'(1);
    end

    assign o_fill        = wr_fill;
    assign o_window_full = wr_ok && (wr_fill == win_len);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                wr_ptr[i] <= '0;
                fill[i]   <= '0;
            end
            if (i_window_len == '0 || i_window_len > DATA_WIDTH'(BUFFER_SIZE))
                win_len <= CNT_W'(BUFFER_SIZE);
            else
                win_len <= CNT_W'(i_window_len);
            state         <= S_IDLE;
            rd_sid        <= '0;
            rd_ptr        <= '0;
            rd_cnt        <= '0;
            o_wr_addr     <= '0;
            o_wr_addr_vld <= 1'b0;
            o_rd_addr     <= '0;
            o_rd_addr_vld <= 1'b0;
            o_rd_last     <= 1'b0;
            o_rd_done     <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_wr_addr_vld <= wr_acc;
            if (wr_acc) begin
                o_wr_addr <= base_of(i_wr_stock_id) + ADDR_W'(wr_ptr[i_wr_stock_id]);
                wr_ptr[i_wr_stock_id] <= (wr_ptr[i_wr_stock_id] == win_len - CNT_W'(1))
                                         ? '0 : wr_ptr[i_wr_stock_id] + CNT_W'(1);
                if (fill[i_wr_stock_id] != win_len)
                    fill[i_wr_stock_id] <= fill[i_wr_stock_id] + CNT_W'(1);
            end
            if (clr_en) begin
                wr_ptr[clr_sid] <= '0;
                fill[clr_sid]   <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (i_rd_req && SID_OK[i_rd_stock_id]) begin
                        rd_sid <= i_rd_stock_id;
                        o_busy <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (sweep_clr || ld_fill == '0) begin
                        o_rd_done <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        rd_cnt        <= ld_fill;
                        rd_ptr        <= ld_ptr;
                        o_rd_addr     <= base_of(rd_sid) + ADDR_W'(ld_ptr);
                        o_rd_addr_vld <= 1'b1;
                        o_rd_last     <= (ld_fill == CNT_W'(1));
                        state         <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    if (sweep_clr || (i_rd_ready && rd_cnt == CNT_W'(1))) begin
                        o_rd_addr_vld <= 1'b0;
                        o_rd_last     <= 1'b0;
                        o_rd_done     <= 1'b1;
                        state         <= S_DONE;
                    end else if (i_rd_ready) begin
                        rd_ptr    <= rd_nxt;
                        rd_cnt    <= rd_cnt - CNT_W'(1);
                        o_rd_addr <= base_of(rd_sid) + ADDR_W'(rd_nxt);
                        o_rd_last <= (rd_cnt == CNT_W'(2));
                    end
                end
                default: begin
                    o_rd_done <= 1'b0;
                    o_busy    <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_volatility_buf_ctrl.sv
// tb/tb_volatility_buf_ctrl.sv - directed self-checking bench for volatility_buf_ctrl
module tb_volatility_buf_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_window_len;
    logic        i_wr_valid;
    logic [1:0]  i_wr_stock_id;
    logic        o_wr_ready;
    logic [6:0]  o_wr_addr;
    logic        o_wr_addr_vld;
    logic [4:0]  o_fill;
    logic        o_window_full;
    logic        i_rd_req;
    logic [1:0]  i_rd_stock_id;
    logic        i_rd_ready;
    logic [6:0]  o_rd_addr;
    logic        o_rd_addr_vld;
    logic        o_rd_last;
    logic        o_rd_done;
    logic        o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    volatility_buf_ctrl #(.NUM_STOCKS(4), .BUFFER_SIZE(20), .DATA_WIDTH(32)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_window_len     (i_window_len),
`ifdef VOL_BUF_CLEAR_EN
        .i_clear          (1'b0),
        .i_clear_stock_id (2'd0),
`endif
        .i_wr_valid       (i_wr_valid),
        .i_wr_stock_id    (i_wr_stock_id),
        .o_wr_ready       (o_wr_ready),
        .o_wr_addr        (o_wr_addr),
        .o_wr_addr_vld    (o_wr_addr_vld),
        .o_fill           (o_fill),
        .o_window_full    (o_window_full),
        .i_rd_req         (i_rd_req),
        .i_rd_stock_id    (i_rd_stock_id),
        .i_rd_ready       (i_rd_ready),
        .o_rd_addr        (o_rd_addr),
        .o_rd_addr_vld    (o_rd_addr_vld),
        .o_rd_last        (o_rd_last),
        .o_rd_done        (o_rd_done),
        .o_busy           (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] wl);
        i_reset      = 1'b1;
        i_window_len = wl;
        tick();
        i_reset      = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sid, input logic [31:0] exp_addr);
        i_wr_valid    = 1'b1;
        i_wr_stock_id = sid;
        tick();
        check("wr_addr", 32'(o_wr_addr), exp_addr);
        check("wr_vld", 32'(o_wr_addr_vld), 32'd1);
        i_wr_valid = 1'b0;
    endtask

    task automatic start_sweep(input logic [1:0] sid);
        i_rd_req      = 1'b1;
        i_rd_stock_id = sid;
        tick();
        i_rd_req = 1'b0;
        check("load_busy", 32'(o_busy), 32'd1);
        check("load_vld", 32'(o_rd_addr_vld), 32'd0);
        tick();
    endtask

    task automatic rd_beat(input logic [31:0] exp_addr, input logic [31:0] exp_last);
        check("rd_vld", 32'(o_rd_addr_vld), 32'd1);
        check("rd_addr", 32'(o_rd_addr), exp_addr);
        check("rd_last", 32'(o_rd_last), exp_last);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] t2_exp [5];
        t2_exp = '{32'd22, 32'd23, 32'd24, 32'd20, 32'd21};
        i_reset = 1'b1; i_window_len = 32'd5; i_wr_valid = 1'b0; i_wr_stock_id = 2'd0;
        i_rd_req = 1'b0; i_rd_stock_id = 2'd0; i_rd_ready = 1'b1;
        do_reset(32'd5);

        check("rst_wr_ready", 32'(o_wr_ready), 32'd1);
        check("rst_wr_vld", 32'(o_wr_addr_vld), 32'd0);
        check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
        check("rst_rd_vld", 32'(o_rd_addr_vld), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_rd_done), 32'd0);
        check("rst_fill", 32'(o_fill), 32'd0);

        // 1: three writes to stock 2
        for (int i = 0; i < 3; i++) wr(2'd2, 32'd40 + 32'(i));
        tick();
        check("t1_vld_drop", 32'(o_wr_addr_vld), 32'd0);
        i_wr_stock_id = 2'd2;
        #1;
        check("t1_fill", 32'(o_fill), 32'd3);
        check("t1_full", 32'(o_window_full), 32'd0);

        // 2: wraparound on stock 1 and full-window sweep
        for (int i = 0; i < 7; i++) wr(2'd1, 32'd20 + 32'(i % 5));
        i_wr_stock_id = 2'd1;
        #1;
        check("t2_fill", 32'(o_fill), 32'd5);
        check("t2_full", 32'(o_window_full), 32'd1);
        start_sweep(2'd1);
        for (int k = 0; k < 5; k++) rd_beat(t2_exp[k], (k == 4) ? 32'd1 : 32'd0);
        check("t2_done", 32'(o_rd_done), 32'd1);
        check("t2_vld_end", 32'(o_rd_addr_vld), 32'd0);
        tick();
        check("t2_done_pulse", 32'(o_rd_done), 32'd0);
        check("t2_idle", 32'(o_busy), 32'd0);

        // 3: empty stock sweep
        i_rd_req = 1'b1; i_rd_stock_id = 2'd3;
        tick();
        i_rd_req = 1'b0;
        check("t3_done_early", 32'(o_rd_done), 32'd0);
        check("t3_vld_a", 32'(o_rd_addr_vld), 32'd0);
        tick();
        check("t3_done", 32'(o_rd_done), 32'd1);
        check("t3_vld_b", 32'(o_rd_addr_vld), 32'd0);
        tick();
        check("t3_idle", 32'(o_busy), 32'd0);

        // 4 + 5: stalled sweep of stock 0 with concurrent writes
        for (int i = 0; i < 4; i++) wr(2'd0, 32'(i));
        tick();
        start_sweep(2'd0);
        rd_beat(32'd0, 32'd0);
        i_rd_ready = 1'b0;
        i_wr_valid = 1'b1; i_wr_stock_id = 2'd0;
        #1;
        check("t5_ready_blocked", 32'(o_wr_ready), 32'd0);
        tick();
        check("t5_drop_vld", 32'(o_wr_addr_vld), 32'd0);
        check("t4_hold1", 32'(o_rd_addr), 32'd1);
        i_wr_stock_id = 2'd3;
        #1;
        check("t5_ready_other", 32'(o_wr_ready), 32'd1);
        tick();
        check("t5_addr60", 32'(o_wr_addr), 32'd60);
        check("t5_vld60", 32'(o_wr_addr_vld), 32'd1);
        check("t4_hold2", 32'(o_rd_addr), 32'd1);
        i_wr_valid = 1'b0;
        tick();
        check("t4_hold3", 32'(o_rd_addr), 32'd1);
        check("t4_hold_vld", 32'(o_rd_addr_vld), 32'd1);
        i_rd_ready = 1'b1;
        rd_beat(32'd1, 32'd0);
        rd_beat(32'd2, 32'd0);
        rd_beat(32'd3, 32'd1);
        check("t4_done", 32'(o_rd_done), 32'd1);
        tick();
        i_wr_stock_id = 2'd0;
        #1;
        check("t4_fill_kept", 32'(o_fill), 32'd4);

        // 6: window clamp to BUFFER_SIZE for 0 and 25
        do_reset(32'd0);
        for (int i = 0; i < 21; i++) wr(2'd0, 32'(i % 20));
        i_wr_stock_id = 2'd0;
        #1;
        check("t6_fill20", 32'(o_fill), 32'd20);
        check("t6_full20", 32'(o_window_full), 32'd1);
        do_reset(32'd25);
        for (int i = 0; i < 21; i++) wr(2'd0, 32'(i % 20));
        tick();

        // 6: reset mid-sweep aborts silently
        start_sweep(2'd0);
        rd_beat(32'd1, 32'd0);
        check("t6_mid_addr", 32'(o_rd_addr), 32'd2);
        i_reset = 1'b1; i_window_len = 32'd5;
        tick();
        i_reset = 1'b0;
        check("t6_rst_vld", 32'(o_rd_addr_vld), 32'd0);
        check("t6_rst_addr", 32'(o_rd_addr), 32'd0);
        check("t6_rst_busy", 32'(o_busy), 32'd0);
        check("t6_rst_last", 32'(o_rd_last), 32'd0);
        check("t6_rst_wr_ready", 32'(o_wr_ready), 32'd1);
        check("t6_rst_fill", 32'(o_fill), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("t6_no_done", 32'(o_rd_done), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
